mem_access: RTL and testbench
=============================

# mem_access

Data-memory access stage of the RISC-V core. It sits between execute and write-back: it takes the ALU effective address and rs2 store data, runs a request/acknowledge transaction with data memory, and aligns and extends load data. The result is presented on `load_write` for the write-back stage. It stalls the front of the pipeline while a transaction is outstanding and reports misaligned, illegal and timed-out accesses.

## Interface
- `MAX_WAIT`, 15: cycles in ACCESS without `mem_ack` before a timeout fault (1..255).
- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: execute has a valid memory instruction this cycle; sampled only in IDLE.
- `memRead` in 1: load instruction.
- `memWrite` in 1: store instruction; wins if both are high.
- `funct3` in 3: width/sign code (loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW).
- `aluOut` in 32: effective byte address.
- `store_data` in 32: rs2 value.
- `mem_req` out 1: request to data memory, held until ack.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{aluOut[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables (bit i = byte lane i).
- `mem_rdata` in 32: read data, valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: transaction complete.
- `load_write` out 32: aligned, extended load result to write-back.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: combinational; holds upstream stages.
- `fault_code` out 2: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid while `done`=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Decoding in IDLE:
  - `start`=1 with neither `memRead` nor `memWrite` is ignored.
  - Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
  - Misaligned: halfword with `aluOut[0]`=1; word with `aluOut[1:0]`≠0.
- IDLE + `start` + valid op, aligned and legal: go to ACCESS. Register `mem_req`=1, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`; clear the wait counter.
- IDLE + `start` + misaligned or illegal: go to DONE with the fault code. No memory request is issued.
  - Illegal takes precedence over misaligned.
- ACCESS:
  - `mem_ack`=1: go to DONE and drop `mem_req`. For loads, capture the extended result into `load_write`.
  - `mem_ack`=0: increment the counter. When the counter reaches `MAX_WAIT`, go to DONE with code 11 and drop `mem_req`.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- Load extraction (byte offset `off` = `aluOut[1:0]`):
  - LB/LBU: `mem_rdata[8*off+7:8*off]`, sign- or zero-extended.
  - LH/LHU: `mem_rdata[16*off[1]+15:16*off[1]]`, sign- or zero-extended.
  - LW: the full word.
- Store lanes:
  - SB: `mem_wdata={4{store_data[7:0]}}`, `mem_be=4'b0001<<off`.
  - SH: `{2{store_data[15:0]}}`, `mem_be=4'b0011<<off`.
  - SW: `store_data`, `4'b1111`.
- `load_write` keeps its value through stores, faults and timeouts.
- `stall` = (IDLE & `start` & (`memRead`|`memWrite`)) | ACCESS.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_be` 0, `load_write` 0, `done` 0, `fault_code` 00, counter 0.
- Reset mid-transaction: `mem_req` drops asynchronously. There is no completion pulse and `load_write` returns to 0.
- Latency, `start` in cycle 0:
  - `mem_req` is high from cycle 1.
  - An ack in cycle 1+k puts `done` in cycle 2+k; zero-wait memory gives `done` in cycle 2.
  - Faulted decode gives `done` in cycle 1.
- `load_write` updates at the same edge that enters DONE and is stable while `done`=1.
- The memory side must hold `mem_ack` for one cycle per request. While `mem_req`=1, all request outputs are stable.
- Timeout: with `mem_req` first high in cycle 1 and no ack, DONE is in cycle 1+`MAX_WAIT`.
  - An ack arriving in the same cycle the counter reaches `MAX_WAIT` wins; it is treated as a normal completion.
- Back-to-back accesses: the earliest next `start` accepted is the cycle after DONE (IDLE).

## Test plan
- LB at `aluOut`=0x1003, `mem_rdata`=0x80FF_FF7F, ack in cycle 1 -> `mem_addr`=0x1000, `load_write`=0xFFFF_FF80, `done` in cycle 2, `fault_code`=00.
- LHU at 0x2002 with `mem_rdata`=0xBEEF_1234 -> `load_write`=0x0000_BEEF. LH with the same data -> 0xFFFF_BEEF.
- SB at 0x0001, `store_data`=0xAABB_CCDD -> `mem_we`=1, `mem_wdata`=0xDDDD_DDDD, `mem_be`=0010. SH at 0x0002 -> `mem_be`=1100. `load_write` is unchanged.
- LW at 0x0006 -> no `mem_req`, `done` in cycle 1, `fault_code`=01. Load with funct3=011 -> `fault_code`=10.
- With `MAX_WAIT`=15 and no ack -> `mem_req` high in cycles 1-15, `done` in cycle 16 with code 11. Ack arriving exactly in cycle 15 -> normal completion, code 00.
- Assert `rst_n`=0 in cycle 2 of an ack-delayed load -> `mem_req` is 0 immediately and the state is IDLE. After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// Handshake and bus bundle between the execute/write-back pipeline, the
// memory-access stage and data memory.
interface mem_access_if;
    logic        start;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluOut;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] load_write;
    logic        done;
    logic        stall;
    logic [1:0]  fault_code;

    modport slave (
        input  start, memRead, memWrite, funct3, aluOut, store_data,
               mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               load_write, done, stall, fault_code
    );

    modport master (
        output start, memRead, memWrite, funct3, aluOut, store_data,
               mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               load_write, done, stall, fault_code
    );
endinterface

// File: rtl/mem_access.sv
// RISC-V data-memory access stage: issues req/ack memory transactions,
// aligns/extends load data and reports misaligned, illegal and timed-out accesses.
module mem_access #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        mem_req_r, mem_we_r, done_r;
    logic [31:0] mem_addr_r, mem_wdata_r, load_write_r;
    logic [3:0]  mem_be_r;
    logic [1:0]  fault_r, fault_nxt_s;
    logic        valid_op_s, illegal_s, misalign_s, timeout_s;

    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Decode of the instruction presented by execute while idle
    always_comb begin
        valid_op_s = bus.start & (bus.memRead | bus.memWrite);
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (bus.memWrite) begin
            illegal_s = (bus.funct3[2] == 1'b1) || (bus.funct3[1:0] == 2'b11);
        end else begin
            illegal_s = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                        (bus.funct3 == 3'b111);
        end
        case (bus.funct3[1:0])
            2'b01:   misalign_s = bus.aluOut[0];
            2'b10:   misalign_s = (bus.aluOut[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Next-state and fault-code selection
    always_comb begin
        state_nxt_s = state_r;
        fault_nxt_s = 2'b00;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_op_s) begin
                    state_nxt_s = (illegal_s || misalign_s) ? DONE : ACCESS;
                    fault_nxt_s = illegal_s ? 2'b10 : (misalign_s ? 2'b01 : 2'b00);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                // an ack in the final wait cycle still counts as a normal completion
                if (bus.mem_ack) begin
                    state_nxt_s = DONE;
                end else if ((cnt_r + 8'd1) == MAX_WAIT_C) begin
                    state_nxt_s = DONE;
                    fault_nxt_s = 2'b11;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Request, result and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            mem_be_r     <= 4'd0;
            load_write_r <= 32'd0;
            done_r       <= 1'b0;
            fault_r      <= 2'b00;
            cnt_r        <= 8'd0;
            f3_r         <= 3'd0;
            off_r        <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (state_nxt_s == ACCESS) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.memWrite;
                        mem_addr_r  <= {bus.aluOut[31:2], 2'b00};
                        mem_wdata_r <= store_lanes(bus.funct3[1:0], bus.store_data);
                        mem_be_r    <= store_be(bus.funct3[1:0], bus.aluOut[1:0]);
                        cnt_r       <= 8'd0;
                        f3_r        <= bus.funct3;
                        off_r       <= bus.aluOut[1:0];
                    end else if (state_nxt_s == DONE) begin
                        done_r  <= 1'b1;
                        fault_r <= fault_nxt_s;
                    end
                end
                ACCESS: begin
                    if (state_nxt_s == DONE) begin
                        mem_req_r <= 1'b0;
                        done_r    <= 1'b1;
                        fault_r   <= fault_nxt_s;
                        if (!timeout_s && !mem_we_r) begin
                            load_write_r <= extract_load(bus.mem_rdata, f3_r, off_r);
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_be     = mem_be_r;
    assign bus.load_write = load_write_r;
    assign bus.done       = done_r;
    assign bus.fault_code = fault_r;
    assign bus.stall      = ((state_r == IDLE) && valid_op_s) || (state_r == ACCESS);
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed test-plan cases followed by
// randomized accesses compared against an arithmetic reference model.
module tb_mem_access;
    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    logic [31:0] lw_model = 32'd0;

    mem_access_if bus ();

    mem_access #(.MAX_WAIT(MAXW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * a[1:0]);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b001:  return 32'($signed(sh[15:0]));
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // one access; ack_cyc = cycle (counted from start) in which ack is given, <=0 means never
    task automatic run_op(input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdata, input int ack_cyc);
        bit legal, mis, acked;
        int nb;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        nb    = nbytes(f3);
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (a % nb) != 0;
        exp_be = 4'((32'd1 << nb) - 32'd1) << a[1:0];
        exp_wd = (nb == 1) ? sd[7:0] * 32'h0101_0101 : (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
        bus.start = 1'b1; bus.memWrite = wr; bus.memRead = rd; bus.funct3 = f3;
        bus.aluOut = a; bus.store_data = sd;
        #1 chk("stall_c0", bus.stall, 32'(wr | rd));
        @(negedge clk);
        bus.start = 1'b0;
        if (!(wr || rd)) begin
            chk("ignored_req", {bus.mem_req, bus.done}, 32'd0);
        end else if (!legal || mis) begin
            chk("fault_done", {bus.done, bus.mem_req}, 32'b10);
            chk("fault_code", bus.fault_code, !legal ? 32'd2 : 32'd1);
            chk("fault_lw", bus.load_write, lw_model);
        end else begin
            acked = 1'b0;
            for (int c = 1; c <= MAXW; c++) begin
                chk("req_held", {bus.mem_req, bus.done, bus.stall}, 32'b101);
                if (c == 1) begin
                    chk("addr", bus.mem_addr, {a[31:2], 2'b00});
                    chk("we", bus.mem_we, 32'(wr));
                    chk("be", bus.mem_be, 32'(exp_be));
                    if (wr) chk("wdata", bus.mem_wdata, exp_wd);
                end
                if (c == ack_cyc) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata; acked = 1'b1;
                end
                @(negedge clk);
                bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
                if (acked) break;
            end
            if (acked && !wr) lw_model = model_load(f3, a, rdata);
            chk("done", {bus.done, bus.mem_req}, 32'b10);
            chk("code", bus.fault_code, acked ? 32'd0 : 32'd3);
            chk("load_write", bus.load_write, lw_model);
        end
        @(negedge clk);
        chk("idle_after", {bus.done, bus.mem_req}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.funct3 = 3'd0;
        bus.aluOut = 32'd0; bus.store_data = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {bus.mem_req, bus.mem_we, bus.mem_be, bus.done, bus.fault_code}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_lw", bus.load_write, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 1, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 1);  // LB -> FFFFFF80
        chk("lb_value", bus.load_write, 32'hFFFF_FF80);
        run_op(0, 1, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 3);  // LHU
        chk("lhu_value", bus.load_write, 32'h0000_BEEF);
        run_op(0, 1, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_1234, 2);  // LH
        chk("lh_value", bus.load_write, 32'hFFFF_BEEF);
        run_op(1, 0, 3'b000, 32'h0000_0001, 32'hAABB_CCDD, 32'd0, 1);  // SB
        run_op(1, 0, 3'b001, 32'h0000_0002, 32'hAABB_CCDD, 32'd0, 1);  // SH
        run_op(1, 1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'd0, 2);  // both high: store
        run_op(0, 1, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 1);          // misaligned LW
        run_op(0, 1, 3'b011, 32'h0000_0006, 32'd0, 32'd0, 1);          // illegal over misaligned
        run_op(1, 0, 3'b100, 32'h0000_0000, 32'd0, 32'd0, 1);          // illegal store
        run_op(0, 0, 3'b010, 32'h0000_0000, 32'd0, 32'd0, 1);          // no op: ignored
        run_op(0, 1, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_2222, 0);  // timeout
        run_op(0, 1, 3'b010, 32'h0000_0044, 32'd0, 32'h3333_4444, MAXW); // late ack wins
        chk("late_ack_value", bus.load_write, 32'h3333_4444);

        // reset in cycle 2 of an ack-delayed load
        bus.start = 1'b1; bus.memRead = 1'b1; bus.memWrite = 1'b0; bus.funct3 = 3'b010;
        bus.aluOut = 32'h0000_0100;
        @(negedge clk);
        bus.start = 1'b0;
        chk("pre_rst_req", bus.mem_req, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_mid_req", {bus.mem_req, bus.done, bus.stall}, 32'd0);
        chk("rst_mid_lw", bus.load_write, 32'd0);
        lw_model = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 1, 3'b010, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 2);

        for (int i = 0; i < 40; i++) begin
            bit w, r;
            int k;
            logic [31:0] ad;
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
            k  = $urandom_range(1, MAXW + 2);
            run_op(w, r, 3'($urandom_range(0, 7)), ad, $urandom, $urandom, (k > MAXW) ? 0 : k);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
